// File: rtl/wbcache_pkg.sv
// Shared constants, FSM encoding and geometry helpers for the wbcache refill path.
package wbcache_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LIN     = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BURST   = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_ABORT   = 3'd4
  } state_t;

  function automatic int tag_bits(input int address, input int wordbits);
    return address - wordbits;
  endfunction

  function automatic int index_bits(input int wordbits, input int linebits);
    return wordbits - linebits;
  endfunction

endpackage

// File: rtl/wbcache_beat_ctr.sv
// Loadable beat counter that wraps inside one cache line; o_last flags the
// beat just before the load point, i.e. the final beat of the burst.
module wbcache_beat_ctr #(
  parameter int LINEBITS = 4
) (
  input  logic                clock,
  input  logic                i_clear,
  input  logic                i_start,
  input  logic [LINEBITS-1:0] i_start_beat,
  input  logic                i_ack,
  output logic [LINEBITS-1:0] o_beat,
  output logic                o_last
);

  logic [LINEBITS-1:0] r_beat;
  logic [LINEBITS-1:0] r_start;
  logic [LINEBITS-1:0] w_beat_inc;

  assign w_beat_inc = r_beat + {{(LINEBITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (i_clear) begin
      r_beat  <= '0;
      r_start <= '0;
    end else if (i_start) begin
      r_beat  <= i_start_beat;
      r_start <= i_start_beat;
    end else if (i_ack) begin
      r_beat  <= w_beat_inc;
    end
  end

  assign o_beat = r_beat;
  assign o_last = (w_beat_inc == r_start);

endmodule

// File: rtl/wbcache_refill_ctrl.sv
// Instruction-cache miss handler: fetches one line over a Wishbone incrementing burst.
// Define WBCACHE_CRITWORD_EN to start the burst at the missed word (wrapping in the line).
module wbcache_refill_ctrl
  import wbcache_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDRESS   = 20,
  parameter int WORDBITS  = 9,
  parameter int LINEBITS  = 4,
  parameter int RETRY_MAX = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         miss_i,
  input  logic [ADDRESS-1:0]           miss_addr_i,
  output logic                         busy_o,
  output logic                         crit_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         fill_we_o,
  output logic [WORDBITS-1:0]          fill_adr_o,
  output logic [WIDTH-1:0]             fill_dat_o,
  output logic                         tag_we_o,
  output logic [WORDBITS-LINEBITS-1:0] tag_idx_o,
  output logic [ADDRESS-WORDBITS-1:0]  tag_o,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic                         wb_we_o,
  output logic [ADDRESS-1:0]           wb_adr_o,
  output logic [2:0]                   wb_cti_o,
  output logic [1:0]                   wb_bte_o,
  input  logic                         wb_ack_i,
  input  logic                         wb_rty_i,
  input  logic                         wb_err_i,
  input  logic [WIDTH-1:0]             wb_dat_i
);

  localparam int IDXW = index_bits(WORDBITS, LINEBITS);
  localparam int TAGW = tag_bits(ADDRESS, WORDBITS);
  localparam int RETW = $clog2(RETRY_MAX + 2);

  state_t              r_state, w_next;
  logic [ADDRESS-1:0]  r_addr;
  logic [RETW-1:0]     r_retry;
  logic                r_busy, r_cyc, r_stb, r_crit, r_done, r_err, r_fill_we, r_tag_we;
  logic [WORDBITS-1:0] r_fill_adr;
  logic [WIDTH-1:0]    r_fill_dat;

  logic                w_start, w_ack, w_rty, w_err, w_last, w_retry_over;
  logic [LINEBITS-1:0] w_beat, w_start_beat;
  logic [IDXW-1:0]     w_index;

  assign w_start = (r_state == ST_IDLE) & miss_i;
  // Terminations only count while we strobe; err beats rty beats ack.
  assign w_err   = r_stb & wb_err_i;
  assign w_rty   = r_stb & wb_rty_i & ~wb_err_i;
  assign w_ack   = r_stb & wb_ack_i & ~wb_rty_i & ~wb_err_i;
  assign w_retry_over = (r_retry == RETW'(RETRY_MAX));
  assign w_index = r_addr[WORDBITS-1:LINEBITS];

`ifdef WBCACHE_CRITWORD_EN
  assign w_start_beat = miss_addr_i[LINEBITS-1:0];
`else
  assign w_start_beat = {LINEBITS{1'b0}};
`endif

  wbcache_beat_ctr #(.LINEBITS(LINEBITS)) u_beat_ctr (
    .clock        (clock),
    .i_clear      (reset),
    .i_start      (w_start),
    .i_start_beat (w_start_beat),
    .i_ack        (w_ack),
    .o_beat       (w_beat),
    .o_last       (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (miss_i) w_next = ST_BURST;
        else        w_next = ST_IDLE;
      end
      ST_BURST: begin
        if (w_err)               w_next = ST_ABORT;
        else if (w_rty)          w_next = w_retry_over ? ST_ABORT : ST_BACKOFF;
        else if (w_ack & w_last) w_next = ST_COMMIT;
        else                     w_next = ST_BURST;
      end
      ST_BACKOFF: w_next = ST_BURST;
      ST_COMMIT:  w_next = ST_IDLE;
      ST_ABORT:   w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Every outward strobe is decoded from the next state so it lines up with that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_retry    <= '0;
      r_busy     <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_crit     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_fill_we  <= 1'b0;
      r_tag_we   <= 1'b0;
      r_fill_adr <= '0;
      r_fill_dat <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr  <= miss_addr_i;
        r_retry <= '0;
      end else if (w_rty) begin
        r_retry <= r_retry + RETW'(1);
      end
      r_busy    <= (w_next != ST_IDLE);
      r_cyc     <= (w_next == ST_BURST);
      r_stb     <= (w_next == ST_BURST);
      r_done    <= (w_next == ST_COMMIT);
      r_tag_we  <= (w_next == ST_COMMIT);
      r_err     <= (w_next == ST_ABORT);
      r_fill_we <= w_ack;
      r_crit    <= w_ack & (w_beat == r_addr[LINEBITS-1:0]);
      if (w_ack) begin
        r_fill_adr <= {w_index, w_beat};
        r_fill_dat <= wb_dat_i;
      end
    end
  end

  assign busy_o     = r_busy;
  assign crit_o     = r_crit;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign fill_we_o  = r_fill_we;
  assign fill_adr_o = r_fill_adr;
  assign fill_dat_o = r_fill_dat;
  assign tag_we_o   = r_tag_we;
  assign tag_idx_o  = w_index;
  assign tag_o      = r_addr[ADDRESS-1:ADDRESS-TAGW];
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = 1'b0;
  assign wb_adr_o   = {r_addr[ADDRESS-1:LINEBITS], w_beat};
  assign wb_cti_o   = r_stb ? (w_last ? CTI_EOB : CTI_INC) : CTI_CLASSIC;
  assign wb_bte_o   = BTE_LIN;

endmodule

// File: tb/tb_wbcache_refill_ctrl.sv
// Bench for wbcache_refill_ctrl: Wishbone slave model with retry/error injection
// and a scoreboard of expected data-RAM writes.
module tb_wbcache_refill_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        miss_i = 1'b0;
  logic [19:0] miss_addr_i = 20'h0;
  logic        busy_o, crit_o, done_o, err_o, fill_we_o, tag_we_o;
  logic [8:0]  fill_adr_o;
  logic [31:0] fill_dat_o;
  logic [4:0]  tag_idx_o;
  logic [10:0] tag_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [19:0] wb_adr_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_rty_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = 32'h0;

  wbcache_refill_ctrl dut (
    .clock(clock), .reset(reset), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .busy_o(busy_o), .crit_o(crit_o), .done_o(done_o), .err_o(err_o),
    .fill_we_o(fill_we_o), .fill_adr_o(fill_adr_o), .fill_dat_o(fill_dat_o),
    .tag_we_o(tag_we_o), .tag_idx_o(tag_idx_o), .tag_o(tag_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i), .wb_rty_i(wb_rty_i),
    .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0]  adr;
    logic [31:0] dat;
    logic        crit;
  } fill_t;

  fill_t       exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_fills = 0;
  int          n_tag_we = 0;
  int          acked = 0;
  int          rty_used = 0;
  int          rty_beat = -1;
  int          rty_n = 0;
  int          err_beat = -1;
  bit          mon_en = 1'b0;
  logic [19:0] m_addr = 20'h0;
  logic [19:0] first_adr = 20'h0;
  logic [19:0] eob_adr = 20'h0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [19:0] a);
    return {12'hC5A, a};
  endfunction

  function automatic logic [3:0] first_beat(input logic [19:0] a);
`ifdef WBCACHE_CRITWORD_EN
    return a[3:0];
`else
    return 4'h0;
`endif
  endfunction

  // Negedge: check last cycle's RAM writes, then drive the slave response for the next edge.
  always @(negedge clock) begin : bus_side
    fill_t       e;
    logic [3:0]  b;
    logic [19:0] ea;
    if (mon_en && !reset) begin
      if (fill_we_o) begin
        n_fills++;
        check_eq("fill_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("fill_adr", 32'(fill_adr_o), 32'(e.adr));
          check_eq("fill_dat", fill_dat_o, e.dat);
          check_eq("fill_crit", 32'(crit_o), 32'(e.crit));
        end
      end else begin
        check_eq("crit_idle", 32'(crit_o), 32'd0);
      end
      if (tag_we_o) n_tag_we++;
    end
    wb_ack_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    if (reset) begin
      exp_q.delete();
    end else if (miss_i && !busy_o) begin
      m_addr   = miss_addr_i;
      acked    = 0;
      rty_used = 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      b  = first_beat(m_addr) + 4'(acked);
      ea = {m_addr[19:4], b};
      check_eq("wb_adr", 32'(wb_adr_o), 32'(ea));
      check_eq("wb_cti", 32'(wb_cti_o), (acked == 15) ? 32'd7 : 32'd2);
      check_eq("wb_we_bte", 32'({wb_we_o, wb_bte_o}), 32'd0);
      if (acked == 0) first_adr = wb_adr_o;
      if (wb_cti_o == 3'b111) eob_adr = wb_adr_o;
      if (acked == err_beat) begin
        wb_err_i = 1'b1;
      end else if (acked == rty_beat && rty_used < rty_n) begin
        wb_rty_i = 1'b1;
        rty_used++;
      end else begin
        wb_ack_i = 1'b1;
        wb_dat_i = word_of(ea);
        exp_q.push_back('{adr: {m_addr[8:4], b}, dat: word_of(ea), crit: (b == m_addr[3:0])});
        acked++;
      end
    end else if (busy_o) begin
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hDEAD_BEEF;
    end
  end

  task automatic run_miss(input logic [19:0] a, input int inj, output int cyc,
                          output logic got_done, output logic got_err);
    @(posedge clock); #1;
    miss_i = 1'b1;
    miss_addr_i = a;
    cyc = 1;
    got_done = 1'b0;
    got_err = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clock); #1;
      cyc++;
      miss_i = (cyc == inj);
      if (cyc == inj) miss_addr_i = 20'h7FFF0;
      if (done_o || err_o) begin
        got_done = done_o;
        got_err = err_o;
        break;
      end
    end
    check_eq("refill_ends", 32'(got_done | got_err), 32'd1);
  endtask

  task automatic check_refill(input string t, input logic [19:0] a, input int lat, input int nf0,
                              input int cyc, input logic gd);
    check_eq({t, "_done"}, 32'(gd), 32'd1);
    check_eq({t, "_lat"}, cyc, lat);
    check_eq({t, "_tag_we"}, 32'(tag_we_o), 32'd1);
    check_eq({t, "_tag_idx"}, 32'(tag_idx_o), 32'(a[8:4]));
    check_eq({t, "_tag"}, 32'(tag_o), 32'(a[19:9]));
    check_eq({t, "_busy_last"}, 32'(busy_o), 32'd1);
    @(posedge clock); #1;
    check_eq({t, "_fills"}, n_fills - nf0, 16);
    check_eq({t, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check_eq({t, "_busy_drop"}, 32'(busy_o), 32'd0);
  endtask

  initial begin : main
    int         cyc;
    int         nf0;
    int         nt0;
    logic       gd, ge;
    logic [3:0] fb;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_strobes", 32'({busy_o, crit_o, done_o, err_o, fill_we_o, tag_we_o, wb_cyc_o, wb_stb_o}), 32'd0);
    check_eq("rst_wb_adr", 32'(wb_adr_o), 32'd0);
    check_eq("rst_cti", 32'(wb_cti_o), 32'd0);
    check_eq("rst_fill", 32'(fill_adr_o) | fill_dat_o, 32'd0);
    check_eq("rst_tag", 32'({tag_idx_o, tag_o}), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Zero-wait refill: index 0x12, tag 0.
    nf0 = n_fills;
    run_miss(20'h00123, 0, cyc, gd, ge);
    check_refill("t1", 20'h00123, 18, nf0, cyc, gd);

    // Start word and end-of-burst position.
    nf0 = n_fills;
    run_miss(20'h00127, 0, cyc, gd, ge);
    check_refill("t2", 20'h00127, 18, nf0, cyc, gd);
    fb = first_beat(20'h00127);
    check_eq("t2_first_adr", 32'(first_adr), 32'({16'h0012, fb}));
    check_eq("t2_eob_adr", 32'(eob_adr), 32'({16'h0012, fb - 4'd1}));

    // One retry on beat 5: rty cycle plus one backoff cycle.
    rty_beat = 5; rty_n = 1;
    nf0 = n_fills;
    run_miss(20'h35A4C, 0, cyc, gd, ge);
    check_refill("t3", 20'h35A4C, 20, nf0, cyc, gd);

    // Four retries exceed the limit.
    rty_beat = 2; rty_n = 4;
    nf0 = n_fills; nt0 = n_tag_we;
    run_miss(20'h1F0E3, 0, cyc, gd, ge);
    check_eq("t4_err", 32'({gd, ge}), 32'd1);
    check_eq("t4_lat", cyc, 11);
    check_eq("t4_busy_at_err", 32'(busy_o), 32'd1);
    @(posedge clock); #1;
    check_eq("t4_busy_drop", 32'(busy_o), 32'd0);
    check_eq("t4_no_tag_we", n_tag_we - nt0, 0);
    check_eq("t4_fills", n_fills - nf0, 2);
    rty_beat = -1; rty_n = 0;

    // Bus error on beat 9, then a clean refill.
    err_beat = 9;
    nf0 = n_fills; nt0 = n_tag_we;
    run_miss(20'h4D3E7, 0, cyc, gd, ge);
    check_eq("t5_err", 32'({gd, ge}), 32'd1);
    check_eq("t5_lat", cyc, 12);
    @(posedge clock); #1;
    check_eq("t5_no_tag_we", n_tag_we - nt0, 0);
    check_eq("t5_fills", n_fills - nf0, 9);
    err_beat = -1;
    nf0 = n_fills;
    run_miss(20'h00200, 0, cyc, gd, ge);
    check_refill("t5b", 20'h00200, 18, nf0, cyc, gd);

    // Reset in the middle of a burst.
    nt0 = n_tag_we;
    @(posedge clock); #1;
    miss_i = 1'b1;
    miss_addr_i = 20'h0ABCD;
    @(posedge clock); #1;
    miss_i = 1'b0;
    for (int k = 0; k < 100 && acked != 7; k++) begin
      @(posedge clock); #1;
    end
    check_eq("t6_reach_beat7", acked, 7);
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("t6_bus_idle", 32'({wb_cyc_o, wb_stb_o, busy_o}), 32'd0);
    check_eq("t6_no_tag_we", 32'(tag_we_o), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("t6_tag_count", n_tag_we - nt0, 0);

    // A miss strobe while busy must not disturb the refill.
    nf0 = n_fills;
    run_miss(20'h00345, 5, cyc, gd, ge);
    check_refill("t6b", 20'h00345, 18, nf0, cyc, gd);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
